// File: rtl/i2c_poll_sched.sv
// i2c_poll_sched: shares one I2C command/start port among four periodically polled
// slots; per-slot countdown/pending/sticky state lives in i2c_poll_slot.

module i2c_poll_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        wr,
  input  logic [15:0] wdata,
  input  logic        issue_clr,
  input  logic        set_err,
  input  logic        set_to,
  output logic [6:0]  addr,
  output logic        pending,
  output logic        overrun,
  output logic        err_st,
  output logic        to_st
);
  logic       en;
  logic [7:0] period, count, wperiod;
  logic       expire;

  // A zero period behaves as one tick so an enabled slot always fires.
  assign wperiod = (wdata[14:7] == 8'd0) ? 8'd1 : wdata[14:7];
  assign expire  = en && tick && (count <= 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= 1'b0;
      period  <= '0;
      addr    <= '0;
      count   <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      err_st  <= 1'b0;
      to_st   <= 1'b0;
    end else if (wr) begin
      en      <= wdata[15];
      period  <= wperiod;
      addr    <= wdata[6:0];
      count   <= wperiod;
      pending <= 1'b0;
      overrun <= 1'b0;
      err_st  <= 1'b0;
      to_st   <= 1'b0;
    end else begin
      if (en && tick) count <= expire ? period : count - 8'd1;
      // A new expiry beats the issue-clear so a back-to-back request is not lost.
      if (!en)            pending <= 1'b0;
      else if (expire)    pending <= 1'b1;
      else if (issue_clr) pending <= 1'b0;
      if (expire && pending) overrun <= 1'b1;
      if (set_err) err_st <= 1'b1;
      if (set_to)  to_st  <= 1'b1;
    end
  end
endmodule

module i2c_poll_sched #(
  parameter int TICK_DIV      = 5000,
  parameter int TIMEOUT_TICKS = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cfg_slot,
  input  logic [15:0] cfg_wdata,
  input  logic        cfg_write,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_err,
  output logic [15:0] i2c_cmd,
  output logic        i2c_start,
  output logic        sched_active,
  output logic [1:0]  sched_slot,
  output logic [15:0] sched_status,
  output logic        res_valid,
  output logic [1:0]  res_slot,
  output logic        res_err,
  output logic        res_timeout
);
  localparam int NUM_SLOTS = 4;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1) + 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t                    state;
  logic [PW-1:0]             pre_cnt;
  logic                      tick;
  logic [TW-1:0]             to_cnt;
  logic [1:0]                ptr, sel, idx;
  logic                      sel_vld;
  logic                      done_w, to_w;
  logic [NUM_SLOTS-1:0]      pend, ovr, errs, tos;
  logic [NUM_SLOTS-1:0]      wr_sel, clr_sel, err_set, to_set;
  logic [NUM_SLOTS-1:0][6:0] addr;

  assign tick = (pre_cnt == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  assign done_w = (state == WAIT) && i2c_done;
  // The first tick after ISSUE only opens the window; TIMEOUT_TICKS more must follow.
  assign to_w   = (state == WAIT) && !i2c_done && tick && (to_cnt == TO_MAX);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign wr_sel[i]  = cfg_write && (cfg_slot == 2'(i));
    assign clr_sel[i] = (state == ISSUE) && (sched_slot == 2'(i));
    assign err_set[i] = done_w && i2c_err && (sched_slot == 2'(i));
    assign to_set[i]  = to_w && (sched_slot == 2'(i));

    i2c_poll_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .wr        (wr_sel[i]),
      .wdata     (cfg_wdata),
      .issue_clr (clr_sel[i]),
      .set_err   (err_set[i]),
      .set_to    (to_set[i]),
      .addr      (addr[i]),
      .pending   (pend[i]),
      .overrun   (ovr[i]),
      .err_st    (errs[i]),
      .to_st     (tos[i])
    );
  end

  assign sched_status = {pend, ovr, errs, tos};

  // Round-robin: first pending slot after the last one issued.
  always_comb begin
    sel     = ptr;
    sel_vld = 1'b0;
    idx     = ptr;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      idx = ptr + 2'(k);
      if (!sel_vld && pend[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 2'd3;
      to_cnt       <= '0;
      i2c_cmd      <= '0;
      i2c_start    <= 1'b0;
      sched_active <= 1'b0;
      sched_slot   <= '0;
      res_valid    <= 1'b0;
      res_slot     <= '0;
      res_err      <= 1'b0;
      res_timeout  <= 1'b0;
    end else begin
      i2c_start <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: if (sel_vld && !i2c_busy) begin
          sched_slot   <= sel;
          ptr          <= sel;
          i2c_cmd      <= {sel, 7'b0, addr[sel]};
          i2c_start    <= 1'b1;
          sched_active <= 1'b1;
          state        <= ISSUE;
        end
        ISSUE: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (done_w || to_w) begin
            res_valid    <= 1'b1;
            res_slot     <= sched_slot;
            res_err      <= done_w && i2c_err;
            res_timeout  <= to_w;
            sched_active <= 1'b0;
            i2c_cmd      <= '0;
            state        <= GAP;
          end else if (tick) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_poll_sched.sv
// Directed bench for i2c_poll_sched with TICK_DIV=4, TIMEOUT_TICKS=2.
module tb_i2c_poll_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cfg_slot = '0;
  logic [15:0] cfg_wdata = '0;
  logic        cfg_write = 1'b0;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_err = 1'b0;
  logic [15:0] i2c_cmd;
  logic        i2c_start;
  logic        sched_active;
  logic [1:0]  sched_slot;
  logic [15:0] sched_status;
  logic        res_valid;
  logic [1:0]  res_slot;
  logic        res_err;
  logic        res_timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;
  int s0, cnt;
  bit ok;

  logic [1:0]  rr_slot [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [15:0] rr_cmd  [5] = '{16'h0010, 16'h4011, 16'h8012, 16'hC013, 16'h0010};

  i2c_poll_sched #(.TICK_DIV(4), .TIMEOUT_TICKS(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_slot     (cfg_slot),
    .cfg_wdata    (cfg_wdata),
    .cfg_write    (cfg_write),
    .i2c_busy     (i2c_busy),
    .i2c_done     (i2c_done),
    .i2c_err      (i2c_err),
    .i2c_cmd      (i2c_cmd),
    .i2c_start    (i2c_start),
    .sched_active (sched_active),
    .sched_slot   (sched_slot),
    .sched_status (sched_status),
    .res_valid    (res_valid),
    .res_slot     (res_slot),
    .res_err      (res_err),
    .res_timeout  (res_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    cfg_write = 1'b0; i2c_busy = 1'b0; i2c_done = 1'b0; i2c_err = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
  endtask

  task automatic cfg_wr(input logic [1:0] s, input logic [15:0] d);
    cfg_slot = s; cfg_wdata = d; cfg_write = 1'b1;
    @(negedge clk);
    cfg_write = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc - base < n) @(negedge clk);
  endtask

  task automatic wait_start(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (i2c_start) found = 1'b1;
    end
    if (!found) chk("start_seen", 0, 1);
  endtask

  task automatic wait_res(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (res_valid) found = 1'b1;
    end
    if (!found) chk("res_seen", 0, 1);
  endtask

  // Pulse done dly cycles after the current (ISSUE) cycle; returns on the res_valid cycle.
  task automatic serve(input int dly, input logic err);
    repeat (dly) @(negedge clk);
    i2c_done = 1'b1; i2c_err = err;
    @(negedge clk);
    i2c_done = 1'b0; i2c_err = 1'b0;
  endtask

  initial begin
    // Reset state and idle behaviour
    @(negedge clk);
    chk("rst_cmd", i2c_cmd, 16'h0000);
    chk("rst_ctl", {i2c_start, sched_active, sched_slot}, 0);
    chk("rst_status", sched_status, 16'h0000);
    chk("rst_res", {res_valid, res_slot, res_err, res_timeout}, 0);
    do_reset();
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (i2c_start) cnt++;
    end
    chk("idle_starts", cnt, 0);
    chk("idle_status", sched_status, 16'h0000);

    // Single slot, period 3 ticks = 12 cycles
    cfg_wr(2'd0, 16'h81C8);
    wait_start(60, ok);
    chk("ss_cmd", i2c_cmd, 16'h0048);
    chk("ss_slot", sched_slot, 0);
    chk("ss_active", sched_active, 1);
    s0 = cyc;
    serve(5, 1'b0);
    chk("ss_rv", res_valid, 1);
    chk("ss_res", {res_slot, res_err, res_timeout}, 0);
    chk("ss_gap", {sched_active, i2c_cmd}, 0);
    @(negedge clk);
    chk("ss_rv_pulse", res_valid, 0);
    wait_start(30, ok);
    chk("ss_period1", cyc - s0, 12);
    s0 = cyc;
    serve(5, 1'b0);
    wait_start(30, ok);
    chk("ss_period2", cyc - s0, 12);
    serve(1, 1'b0);

    // Round-robin 0,1,2 then 3,0 after enabling slot 3
    do_reset();
    cfg_wr(2'd0, 16'h8090);
    cfg_wr(2'd1, 16'h8091);
    cfg_wr(2'd2, 16'h8092);
    for (int k = 0; k < 5; k++) begin
      wait_start(40, ok);
      chk("rr_slot", sched_slot, rr_slot[k]);
      chk("rr_cmd", i2c_cmd, rr_cmd[k]);
      if (k == 2) begin
        cfg_wr(2'd3, 16'h8093);
        serve(5, 1'b0);
      end else begin
        serve(1, 1'b0);
      end
      chk("rr_res_slot", res_slot, rr_slot[k]);
    end

    // Timeout, sticky clear by cfg_write, disable during WAIT still reports
    do_reset();
    cfg_wr(2'd0, 16'h80A2);
    wait_start(40, ok);
    chk("to_cmd", i2c_cmd, 16'h0022);
    s0 = cyc;
    wait_res(40, ok);
    chk("to_flag", {res_timeout, res_err, res_slot}, 4'b1000);
    chk("to_sticky", sched_status[0], 1);
    chk("to_window", ((cyc - s0) >= 10) && ((cyc - s0) <= 13), 1);
    cfg_wr(2'd0, 16'h80A2);
    chk("to_clr", sched_status, 16'h0000);
    wait_start(40, ok);
    cfg_wr(2'd0, 16'h0000);
    wait_res(40, ok);
    chk("dis_res", {res_timeout, res_slot}, 3'b100);
    chk("dis_status", sched_status, 16'h0001);

    // Overrun under busy, then error completion
    do_reset();
    i2c_busy = 1'b1;
    cfg_wr(2'd2, 16'h80B3);
    repeat (12) @(negedge clk);
    chk("ovr_bits", {sched_status[14], sched_status[10]}, 2'b11);
    chk("ovr_noissue", sched_active, 0);
    i2c_busy = 1'b0;
    wait_start(10, ok);
    chk("err_cmd", i2c_cmd, 16'h8033);
    serve(2, 1'b1);
    chk("err_res", {res_valid, res_err, res_timeout, res_slot}, 5'b11010);
    chk("err_sticky", {sched_status[10], sched_status[6]}, 2'b11);

    // Config write colliding with the expiry tick
    do_reset();
    i2c_busy = 1'b1;
    wait_until(1);
    cfg_wr(2'd1, 16'h8111);
    wait_until(7);
    cfg_wr(2'd1, 16'h8111);
    chk("col_pend", sched_status[13], 0);
    wait_until(15);
    chk("col_pend_pre", sched_status[13], 0);
    wait_until(16);
    chk("col_pend_post", sched_status[13], 1);

    // Asynchronous reset during WAIT, then stray done
    i2c_busy = 1'b0;
    wait_start(10, ok);
    @(negedge clk);
    chk("rw_active", sched_active, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_cmd", i2c_cmd, 16'h0000);
    chk("rw_ctl", {sched_active, i2c_start, res_valid}, 0);
    chk("rw_status", sched_status, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid || i2c_start) cnt++;
      i2c_done = (i == 3);
    end
    i2c_done = 1'b0;
    chk("rw_quiet", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_poll_sched.md
# i2c_poll_sched

Periodic poll scheduler that shares the single I2C interface among four device slots. Each slot holds an enable, a poll period and a 7-bit I2C address. The block counts down each slot's period and picks pending slots round-robin. It issues one start per poll, then tracks completion, errors, timeouts and overruns. It sits between the ureg configuration space and the I2C interface command/start port, in the same position the autoread path occupies.

## Interface
- TICK_DIV, 5000: clk cycles per scheduler tick (0.1 ms at 50 MHz)
- TIMEOUT_TICKS, 100: ticks allowed from start to done before abort (10 ms)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- cfg_slot  in  2  slot index for cfg_write
- cfg_wdata  in  16  slot config: [15] enable, [14:7] period in ticks, [6:0] I2C address
- cfg_write  in  1  one-cycle write strobe
- i2c_busy  in  1  I2C interface busy
- i2c_done  in  1  one-cycle transaction-complete pulse
- i2c_err  in  1  NACK/error, sampled only with i2c_done
- i2c_cmd  out  16  {slot[1:0], 7'b0, addr[6:0]}, held from ISSUE through WAIT
- i2c_start  out  1  one-cycle start pulse
- sched_active  out  1  high in ISSUE and WAIT
- sched_slot  out  2  slot currently or last issued
- sched_status  out  16  [15:12] pending, [11:8] overrun, [7:4] error, [3:0] timeout (bit n = slot n)
- res_valid  out  1  one-cycle result pulse
- res_slot  out  2  slot of the result
- res_err  out  1  i2c_err captured with done
- res_timeout  out  1  result produced by timeout

## Operation
- Reset: all outputs 0, all slot configs 0 (disabled), countdowns 0, sticky bits 0, FSM IDLE, round-robin pointer = 3 so slot 0 wins first.
- Prescaler: 0..TICK_DIV-1 free-running counter; tick is high for one cycle when it wraps.
- Config write: stores enable/period/addr, loads countdown = period (0 treated as 1), clears that slot's pending and all its sticky bits. It takes precedence over a same-cycle tick expiry on that slot.
- Countdown, per enabled slot on tick:
  - count > 1: decrement.
  - count == 1: reload with period and request pending. If pending is already set, set the overrun sticky; pending stays 1.
  - Disabled slots do not count, and their pending bit is forced to 0.
- FSM:
  - IDLE: if any pending and !i2c_busy, choose the first pending slot scanning from pointer+1 (mod 4), latch it into sched_slot/pointer, go ISSUE.
  - ISSUE (1 cycle): i2c_start=1, i2c_cmd valid, clear that slot's pending, clear the timeout counter, go WAIT.
  - WAIT: on i2c_done, pulse res_valid next cycle with res_err=i2c_err, set the error sticky if err, go GAP. Otherwise, if the timeout counter reaches TIMEOUT_TICKS (counts ticks), pulse res_valid with res_timeout=1, set the timeout sticky, go GAP.
  - GAP (1 cycle): go IDLE. i2c_cmd returns to 0.
- Disabling the active slot during WAIT does not abort the transaction; its result is still reported.
- i2c_done outside WAIT is ignored.
- If pending-set and ISSUE-clear of the same slot coincide, the set wins and the slot stays pending.
- Asynchronous reset mid-transaction aborts immediately with no res_valid. The I2C interface is not notified.

## Timing
- Pending is visible in sched_status one cycle after the tick.
- Pending seen in IDLE at cycle N with bus idle: i2c_start high at N+1.
- i2c_done at cycle M: res_valid at M+1, FSM back in IDLE at M+2, next start earliest at M+3.
- Minimum spacing between starts is 4 cycles (ISSUE, WAIT≥1, GAP, IDLE).
- The timeout window starts at the first tick after ISSUE, so actual time is TIMEOUT_TICKS to TIMEOUT_TICKS+1 ticks.
- res_* fields hold their value until the next res_valid. Only res_valid pulses.

## Test plan
- Reset then idle: all outputs 0, no i2c_start for 10 ticks with no slot enabled.
- Single slot: TICK_DIV=4, slot0 cfg 0x8000|(3<<7)|0x48 → i2c_start every 12 cycles, i2c_cmd=0x0048; done 5 cycles after start → res_valid, res_slot=0, res_err=0.
- Round-robin: slots 0,1,2 all period 1 pending together → starts in order 0,1,2. After slot 3 is enabled, order continues 3,0.
- Timeout: TIMEOUT_TICKS=2, never assert done → res_valid with res_timeout=1 after 2–3 ticks, sched_status[0]=1. A cfg_write to slot 0 clears it.
- Overrun/error: hold i2c_busy high across two expiries of slot 2 → sched_status[10]=1. Then done with i2c_err=1 → res_err=1 and sched_status[6]=1.
- Collision/reset: cfg_write on the expiry tick leaves pending=0. rst_n low during WAIT → outputs 0 immediately and no res_valid.
